// File: rtl/ruler_sweep_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : ruler_sweep_ctrl_pkg
// Brief  : Shared definitions for the ruler LED bar sweep controller:
//          direction encodings, FSM state encodings, default parameter values
//          and width-generic corner patterns.
// Rev    : 1.0 - initial release
// ============================================================================
package ruler_sweep_ctrl_pkg;

  // Direction of the next move
  localparam logic DIR_RIGHT = 1'b1;  // toward LSB
  localparam logic DIR_LEFT  = 1'b0;  // toward MSB

  // Default configuration
  localparam int DEF_RULER_WIDTH = 8;
  localparam int DEF_TICK_DIV    = 50000000;  // 1 s at 50 MHz
  localparam int DEF_DWELL_TICKS = 4;

  // Corner patterns are built in a wide vector and cut down to the bar width
  localparam int MAX_RULER_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DWELL = 2'd2
  } state_e;

  // Left corner: only the MSB of a 'width'-bit bar lit
  function automatic logic [MAX_RULER_WIDTH-1:0] lcorner(input int width);
    return {{(MAX_RULER_WIDTH-1){1'b0}}, 1'b1} << (width - 1);
  endfunction

  // Right corner: only the LSB lit, independent of the bar width
  function automatic logic [MAX_RULER_WIDTH-1:0] rcorner();
    return {{(MAX_RULER_WIDTH-1){1'b0}}, 1'b1};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ruler_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : ruler_sweep_ctrl_if
// Brief  : Control/status bundle between the sweep controller and the ruler
//          datapath / board buttons.
//   run_i    - level, 1 = free-running sweep
//   mode_i   - 0 = bounce at corners, 1 = wrap
//   step_i   - single-cycle manual move request (honoured while frozen)
//   stb_o    - one-cycle pulse when pos_o takes a new value
//   dir_o    - direction of the next move (1 = right / toward LSB)
//   pos_o    - one-hot lit position
//   corner_o - pos_o sits on either corner
//   master modport: controller side; slave modport: consumer side.
// Rev    : 1.0 - initial release
// ============================================================================
interface ruler_sweep_ctrl_if #(
  parameter int RULER_WIDTH = 8
);
  logic                   run_i;
  logic                   mode_i;
  logic                   step_i;
  logic                   stb_o;
  logic                   dir_o;
  logic [RULER_WIDTH-1:0] pos_o;
  logic                   corner_o;

  modport master (
    input  run_i, mode_i, step_i,
    output stb_o, dir_o, pos_o, corner_o
  );

  modport slave (
    output run_i, mode_i, step_i,
    input  stb_o, dir_o, pos_o, corner_o
  );
endinterface
`default_nettype wire

// File: rtl/ruler_sweep_ctrl_prescaler.sv
`default_nettype none
// ============================================================================
// Module : ruler_sweep_ctrl_prescaler
// Brief  : Divides clk_i into sweep ticks. Counts 0..TICK_DIV-1 while en_i is
//          high and wraps; tick_o marks the terminal count. Dropping en_i
//          clears the count so a fresh enable always waits a full period.
//   clk_i  - clock
//   rst_i  - asynchronous reset, active-high
//   en_i   - count enable
//   tick_o - high for one cycle every TICK_DIV enabled cycles
// Rev    : 1.0 - initial release
// ============================================================================
module ruler_sweep_ctrl_prescaler
  import ruler_sweep_ctrl_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int            CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = '0;
    if (en_i && !tick_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ruler_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module : ruler_sweep_ctrl
// Brief  : Sequencer for the ruler LED bar. Walks a one-hot position across
//          the bar once per sweep tick, bouncing at the corners or wrapping,
//          and strobes stb_o in the cycle the position changes.
//          Optional corner dwell is compiled in with RULER_CTRL_DWELL_EN:
//          in bounce mode a move landing on a corner holds for DWELL_TICKS
//          ticks before sweeping on.
//   clk_i - clock, rising edge
//   rst_i - asynchronous reset, active-high
//   bus   - ruler_sweep_ctrl_if.master (run/mode/step in, stb/dir/pos/corner out)
// Rev    : 1.0 - initial release
// ============================================================================
module ruler_sweep_ctrl
  import ruler_sweep_ctrl_pkg::*;
#(
  parameter int RULER_WIDTH = DEF_RULER_WIDTH,
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int DWELL_TICKS = DEF_DWELL_TICKS
) (
  input  logic                clk_i,
  input  logic                rst_i,
  ruler_sweep_ctrl_if.master  bus
);

  localparam logic [RULER_WIDTH-1:0] LCORNER = RULER_WIDTH'(lcorner(RULER_WIDTH));
  localparam logic [RULER_WIDTH-1:0] RCORNER = RULER_WIDTH'(rcorner());

  state_e                 state_q, state_d;
  logic [RULER_WIDTH-1:0] pos_q, pos_d;
  logic                   dir_q, dir_d;
  logic                   stb_q, stb_d;

  logic                   tick;
  logic                   presc_en;
  logic                   move;
  logic [RULER_WIDTH-1:0] next_pos;
  logic                   next_dir;

  // One move of the sweep. pos is one-hot, so testing a single bit is enough
  // to know whether we sit on the corner in the direction of travel.
  function automatic logic [RULER_WIDTH:0] next_move(
    input logic [RULER_WIDTH-1:0] pos,
    input logic                   dir,
    input logic                   wrap
  );
    logic [RULER_WIDTH-1:0] p;
    logic                   d;
    p = pos;
    d = dir;
    if (dir == DIR_RIGHT) begin
      if (pos[0]) begin
        if (wrap) begin
          p = LCORNER;
        end else begin
          p = pos << 1;
          d = DIR_LEFT;
        end
      end else begin
        p = pos >> 1;
      end
    end else begin
      if (pos[RULER_WIDTH-1]) begin
        if (wrap) begin
          p = RCORNER;
        end else begin
          p = pos >> 1;
          d = DIR_RIGHT;
        end
      end else begin
        p = pos << 1;
      end
    end
    return {d, p};
  endfunction

  // The prescaler only runs while the sweep is live; the cycle run_i drops
  // already clears it so a restart always waits a full tick period.
  assign presc_en = bus.run_i && (state_q != ST_IDLE);

  ruler_sweep_ctrl_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (presc_en),
    .tick_o (tick)
  );

  assign {next_dir, next_pos} = next_move(pos_q, dir_q, bus.mode_i);

`ifdef RULER_CTRL_DWELL_EN
  localparam int DWELL_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST =
    DWELL_W'((DWELL_TICKS > 0) ? (DWELL_TICKS - 1) : 0);

  logic [DWELL_W-1:0] dwell_q, dwell_d;
`else
  // The dwell length has no meaning without the dwell feature
  logic unused_dwell_ticks;
  assign unused_dwell_ticks = (DWELL_TICKS != 0);
`endif

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    move    = 1'b0;
`ifdef RULER_CTRL_DWELL_EN
    dwell_d = dwell_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.run_i) begin
          state_d = ST_RUN;
        end else if (bus.step_i) begin
          move = 1'b1;
        end
      end

      ST_RUN: begin
        if (!bus.run_i) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          move = 1'b1;
        end
      end

`ifdef RULER_CTRL_DWELL_EN
      ST_DWELL: begin
        if (!bus.run_i) begin
          state_d = ST_IDLE;
          dwell_d = '0;
        end else if (tick) begin
          if (dwell_q == DWELL_LAST) begin
            state_d = ST_RUN;
            dwell_d = '0;
          end else begin
            dwell_d = dwell_q + DWELL_W'(1);
          end
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (move) begin
      pos_d = next_pos;
      dir_d = next_dir;
`ifdef RULER_CTRL_DWELL_EN
      // Only a running bounce-mode sweep pauses on a corner; manual steps
      // stay in IDLE and wrap mode never dwells.
      if ((state_q == ST_RUN) && !bus.mode_i && (DWELL_TICKS != 0) &&
          (next_pos[0] || next_pos[RULER_WIDTH-1])) begin
        state_d = ST_DWELL;
        dwell_d = '0;
      end
`endif
    end

    // Strobe is registered alongside pos so both change on the same edge
    stb_d = move;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      pos_q   <= LCORNER;
      dir_q   <= DIR_RIGHT;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      stb_q   <= stb_d;
    end
  end

`ifdef RULER_CTRL_DWELL_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dwell_q <= '0;
    end else begin
      dwell_q <= dwell_d;
    end
  end
`endif

  assign bus.stb_o    = stb_q;
  assign bus.dir_o    = dir_q;
  assign bus.pos_o    = pos_q;
  assign bus.corner_o = pos_q[0] | pos_q[RULER_WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_ruler_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_ruler_sweep_ctrl
// Brief  : Directed self-checking bench for ruler_sweep_ctrl (8-bit bar and a
//          2-bit bar, TICK_DIV=4). Corner dwell expectations follow
//          RULER_CTRL_DWELL_EN with DWELL_TICKS=2.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ruler_sweep_ctrl;

  // Extra cycles before the move that leaves a bounce corner (2 ticks x 4)
`ifdef RULER_CTRL_DWELL_EN
  localparam int DW = 8;
`else
  localparam int DW = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  ruler_sweep_ctrl_if #(.RULER_WIDTH(8)) bus ();
  ruler_sweep_ctrl_if #(.RULER_WIDTH(2)) bus2 ();

  ruler_sweep_ctrl #(
    .RULER_WIDTH (8),
    .TICK_DIV    (4),
    .DWELL_TICKS (2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  ruler_sweep_ctrl #(
    .RULER_WIDTH (2),
    .TICK_DIV    (4),
    .DWELL_TICKS (0)
  ) dut2 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus2)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the next strobe on the 8-bit bar and check the move
  task automatic mv(input string tag, input int exp_n, input logic [7:0] exp_pos,
                    input logic exp_dir);
    int n;
    n = 0;
    do begin
      clk_step();
      n++;
    end while (!bus.stb_o && n < 100);
    check_val({tag, "_lat"}, 32'(n), 32'(exp_n));
    check_val({tag, "_pos"}, 32'(bus.pos_o), 32'(exp_pos));
    check_val({tag, "_dir"}, 32'(bus.dir_o), 32'(exp_dir));
    check_val({tag, "_corner"}, 32'(bus.corner_o),
              32'((exp_pos == 8'h80) || (exp_pos == 8'h01)));
  endtask

  task automatic mv2(input string tag, input int exp_n, input logic [1:0] exp_pos,
                     input logic exp_dir);
    int n;
    n = 0;
    do begin
      clk_step();
      n++;
    end while (!bus2.stb_o && n < 100);
    check_val({tag, "_lat"}, 32'(n), 32'(exp_n));
    check_val({tag, "_pos"}, 32'(bus2.pos_o), 32'(exp_pos));
    check_val({tag, "_dir"}, 32'(bus2.dir_o), 32'(exp_dir));
    check_val({tag, "_corner"}, 32'(bus2.corner_o), 32'd1);
  endtask

  initial begin
    int seen;
    bus.run_i   = 1'b0;
    bus.mode_i  = 1'b0;
    bus.step_i  = 1'b0;
    bus2.run_i  = 1'b0;
    bus2.mode_i = 1'b0;
    bus2.step_i = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) clk_step();
    rst = 1'b0;
    check_val("rst_pos", 32'(bus.pos_o), 32'h80);
    check_val("rst_dir", 32'(bus.dir_o), 32'd1);
    check_val("rst_stb", 32'(bus.stb_o), 32'd0);
    check_val("rst_corner", 32'(bus.corner_o), 32'd1);
    check_val("rst_pos_w2", 32'(bus2.pos_o), 32'h2);

    // ---------------- test 1: async reset mid-sweep ----------------
    bus.run_i = 1'b1;
    mv("t1_first", 5, 8'h40, 1'b1);
    mv("t1_m2", 4, 8'h20, 1'b1);
    mv("t1_m3", 4, 8'h10, 1'b1);
    repeat (2) clk_step();
    #3 rst = 1'b1;
    #1;
    check_val("t1_async_pos", 32'(bus.pos_o), 32'h80);
    check_val("t1_async_dir", 32'(bus.dir_o), 32'd1);
    check_val("t1_async_stb", 32'(bus.stb_o), 32'd0);
    clk_step();
    rst = 1'b0;
    mv("t1_post", 5, 8'h40, 1'b1);
    clk_step();
    check_val("t1_stb_one_cycle", 32'(bus.stb_o), 32'd0);

    // ---------------- test 2: bounce full period ----------------
    mv("t2_a", 3, 8'h20, 1'b1);
    mv("t2_b", 4, 8'h10, 1'b1);
    mv("t2_c", 4, 8'h08, 1'b1);
    mv("t2_d", 4, 8'h04, 1'b1);
    mv("t2_e", 4, 8'h02, 1'b1);
    mv("t2_f", 4, 8'h01, 1'b1);
    mv("t2_g", 4 + DW, 8'h02, 1'b0);
    mv("t2_h", 4, 8'h04, 1'b0);
    mv("t2_i", 4, 8'h08, 1'b0);
    mv("t2_j", 4, 8'h10, 1'b0);
    mv("t2_k", 4, 8'h20, 1'b0);
    mv("t2_l", 4, 8'h40, 1'b0);
    mv("t2_m", 4, 8'h80, 1'b0);
    mv("t2_n", 4 + DW, 8'h40, 1'b1);

    // ---------------- test 3: wrap, then back to bounce ----------------
    mv("t3_a", 4, 8'h20, 1'b1);
    mv("t3_b", 4, 8'h10, 1'b1);
    mv("t3_c", 4, 8'h08, 1'b1);
    mv("t3_d", 4, 8'h04, 1'b1);
    mv("t3_e", 4, 8'h02, 1'b1);
    bus.mode_i = 1'b1;
    mv("t3_w1", 4, 8'h01, 1'b1);
    mv("t3_w2", 4, 8'h80, 1'b1);
    mv("t3_w3", 4, 8'h40, 1'b1);
    mv("t3_w4", 4, 8'h20, 1'b1);
    mv("t3_w5", 4, 8'h10, 1'b1);
    mv("t3_w6", 4, 8'h08, 1'b1);
    mv("t3_w7", 4, 8'h04, 1'b1);
    mv("t3_w8", 4, 8'h02, 1'b1);
    mv("t3_w9", 4, 8'h01, 1'b1);
    bus.mode_i = 1'b0;
    mv("t3_back", 4, 8'h02, 1'b0);

    // ---------------- test 4: pause and manual step ----------------
    mv("t4_a", 4, 8'h04, 1'b0);
    mv("t4_b", 4, 8'h08, 1'b0);
    mv("t4_c", 4, 8'h10, 1'b0);
    mv("t4_d", 4, 8'h20, 1'b0);
    mv("t4_e", 4, 8'h40, 1'b0);
    mv("t4_f", 4, 8'h80, 1'b0);
    mv("t4_g", 4 + DW, 8'h40, 1'b1);
    mv("t4_h", 4, 8'h20, 1'b1);
    mv("t4_i", 4, 8'h10, 1'b1);
    bus.run_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      clk_step();
      if (bus.stb_o) seen++;
    end
    check_val("t4_frozen_stb", 32'(seen), 32'd0);
    check_val("t4_frozen_pos", 32'(bus.pos_o), 32'h10);
    bus.step_i = 1'b1;
    clk_step();
    bus.step_i = 1'b0;
    check_val("t4_step_stb", 32'(bus.stb_o), 32'd1);
    check_val("t4_step_pos", 32'(bus.pos_o), 32'h08);
    check_val("t4_step_dir", 32'(bus.dir_o), 32'd1);
    clk_step();
    check_val("t4_step_once_stb", 32'(bus.stb_o), 32'd0);
    check_val("t4_step_once_pos", 32'(bus.pos_o), 32'h08);
    bus.run_i = 1'b1;
    seen = 0;
    repeat (2) begin
      clk_step();
      if (bus.stb_o) seen++;
    end
    bus.step_i = 1'b1;
    clk_step();
    if (bus.stb_o) seen++;
    bus.step_i = 1'b0;
    check_val("t4_run_step_ignored", 32'(seen), 32'd0);
    mv("t4_run_move", 2, 8'h04, 1'b1);

    // ---------------- test 5: corner dwell ----------------
    mv("t5_a", 4, 8'h02, 1'b1);
    mv("t5_b", 4, 8'h01, 1'b1);
    mv("t5_c", 4 + DW, 8'h02, 1'b0);
`ifdef RULER_CTRL_DWELL_EN
    mv("t5_d", 4, 8'h04, 1'b0);
    mv("t5_e", 4, 8'h08, 1'b0);
    mv("t5_f", 4, 8'h10, 1'b0);
    mv("t5_g", 4, 8'h20, 1'b0);
    mv("t5_h", 4, 8'h40, 1'b0);
    mv("t5_i", 4, 8'h80, 1'b0);
    seen = 0;
    repeat (5) begin
      clk_step();
      if (bus.stb_o) seen++;
    end
    bus.run_i = 1'b0;
    repeat (3) begin
      clk_step();
      if (bus.stb_o) seen++;
    end
    check_val("t5_dwell_abort_stb", 32'(seen), 32'd0);
    bus.run_i = 1'b1;
    mv("t5_restart", 5, 8'h40, 1'b1);
`endif
    bus.run_i = 1'b0;

    // ---------------- test 6: 2-bit bar ----------------
    bus2.run_i = 1'b1;
    mv2("t6_a", 5, 2'b01, 1'b1);
    mv2("t6_b", 4, 2'b10, 1'b0);
    mv2("t6_c", 4, 2'b01, 1'b1);
    mv2("t6_d", 4, 2'b10, 1'b0);
    bus2.run_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
